// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target blocks.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX,
      RX_ACK,
      TX,
      TX_ACK,
      IGNORE
   } i2c_state_t;

   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;
   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA onto clk and flags SCL edges plus START/STOP.
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl;
   logic                   scl_q;
   logic                   sda_q;

   // Idle bus level is high, so reset to 1 to avoid phantom edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_q    <= scl;
         sda_q    <= sda;
      end
   end

   assign scl      = scl_sync[SYNC_STAGES-1];
   assign sda      = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;
   assign start    = scl & scl_q & sda_q & ~sda;
   assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target with fixed address, byte-wide rx/tx handshake, open-drain SDA.
module i2c_slave_core
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h2a,
   parameter int         SYNC_STAGES = 2,
   parameter int         HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_first,
   output logic       tx_req,
   input  logic [7:0] tx_data,
   output logic       busy
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   i2c_state_t state, state_n;

   logic          sda;
   logic          scl_rise;
   logic          scl_fall;
   logic          start;
   logic          stop;
   logic [2:0]    bit_cnt;
   logic          full;
   logic          rw;
   logic          first;
   logic [7:0]    shifter;
   logic [HW-1:0] hold_cnt;
   logic          oe_val;
   logic          last_rise;
   logic          addr_hit;
   logic          counting;

   i2c_bus_monitor #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_mon (
      .clk     (clk),
      .rst     (rst),
      .scl_i   (scl_i),
      .sda_i   (sda_i),
      .sda     (sda),
      .scl_rise(scl_rise),
      .scl_fall(scl_fall),
      .start   (start),
      .stop    (stop)
   );

   assign last_rise = scl_rise && (bit_cnt == 3'd7);
   assign addr_hit  = (shifter[6:0] == SLAVE_ADDR);
   assign counting  = (state == ADDR) || (state == RX) || (state == TX);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (start) begin
         state_n = ADDR;
      end else if (stop) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            ADDR: begin
               if (last_rise && !addr_hit) state_n = IGNORE;
               else if (scl_fall && full)  state_n = ADDR_ACK;
            end
            ADDR_ACK: begin
               if (scl_fall) state_n = (rw == I2C_READ) ? TX : RX;
            end
            RX: begin
               if (scl_fall && full) state_n = RX_ACK;
            end
            RX_ACK: begin
               if (scl_fall) state_n = RX;
            end
            TX: begin
               if (scl_fall && full) state_n = TX_ACK;
            end
            TX_ACK: begin
               if (scl_rise && sda == I2C_NACK) state_n = IGNORE;
               else if (scl_fall)               state_n = TX;
            end
            default: ;
         endcase
      end
   end

   // SDA changes are queued in oe_val and applied HOLD_CYCLES after the SCL fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sda_oe   <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         rx_first <= 1'b0;
         tx_req   <= 1'b0;
         busy     <= 1'b0;
         bit_cnt  <= 3'd0;
         full     <= 1'b0;
         rw       <= I2C_WRITE;
         first    <= 1'b0;
         shifter  <= 8'h00;
         hold_cnt <= '0;
         oe_val   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
            if (hold_cnt == HW'(1)) sda_oe <= oe_val;
         end
         if (start || stop) begin
            sda_oe   <= 1'b0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            bit_cnt  <= 3'd0;
            full     <= 1'b0;
         end else begin
            if (scl_rise && counting) begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) full <= 1'b1;
            end
            unique case (state)
               ADDR: begin
                  if (scl_rise) shifter <= {shifter[6:0], sda};
                  if (last_rise) begin
                     rw     <= sda;
                     tx_req <= addr_hit && (sda == I2C_READ);
                  end
                  if (scl_fall && full) begin
                     full     <= 1'b0;
                     busy     <= 1'b1;
                     oe_val   <= 1'b1;
                     hold_cnt <= HW'(HOLD_CYCLES);
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     first    <= 1'b1;
                     bit_cnt  <= 3'd0;
                     hold_cnt <= HW'(HOLD_CYCLES);
                     if (rw == I2C_READ) begin
                        shifter <= tx_data;
                        oe_val  <= ~tx_data[7];
                     end else begin
                        oe_val  <= 1'b0;
                     end
                  end
               end
               RX: begin
                  if (scl_rise) shifter <= {shifter[6:0], sda};
                  if (last_rise) begin
                     rx_data  <= {shifter[6:0], sda};
                     rx_valid <= 1'b1;
                     rx_first <= first;
                     first    <= 1'b0;
                  end
                  if (scl_fall && full) begin
                     full     <= 1'b0;
                     oe_val   <= 1'b1;
                     hold_cnt <= HW'(HOLD_CYCLES);
                  end
               end
               RX_ACK: begin
                  if (scl_fall) begin
                     oe_val   <= 1'b0;
                     hold_cnt <= HW'(HOLD_CYCLES);
                  end
               end
               TX: begin
                  if (scl_fall) begin
                     hold_cnt <= HW'(HOLD_CYCLES);
                     if (full) begin
                        full    <= 1'b0;
                        oe_val  <= 1'b0;
                     end else begin
                        shifter <= {shifter[6:0], 1'b0};
                        oe_val  <= ~shifter[6];
                     end
                  end
               end
               TX_ACK: begin
                  if (scl_rise && sda == I2C_ACK) tx_req <= 1'b1;
                  if (scl_fall) begin
                     shifter  <= tx_data;
                     oe_val   <= ~tx_data[7];
                     hold_cnt <= HW'(HOLD_CYCLES);
                     bit_cnt  <= 3'd0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench: bit-banged 400 kHz master on a wired-AND SDA, checked against transaction-level expectations.
`timescale 1ns/1ps
module tb_i2c_slave_core;

   localparam time Q = 625;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl_m = 1'b1;
   logic       m_low = 1'b0;
   logic [7:0] tx_data = 8'hFF;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_first;
   logic       tx_req;
   logic       busy;
   wire        sda_bus = ~(sda_oe | m_low);

   int total = 0;
   int bad = 0;

   logic [7:0] wq[$];
   logic [7:0] rd_q[$];
   logic [7:0] rxq[$];
   logic       rfq[$];
   logic [7:0] txsrc[$];
   logic       got_ack;
   int         nacks;
   int         txreq_n;
   bit         oe_seen;
   bit         busy_seen;

   i2c_slave_core dut (
      .clk     (clk),
      .rst     (rst),
      .scl_i   (scl_m),
      .sda_i   (sda_bus),
      .sda_oe  (sda_oe),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_first(rx_first),
      .tx_req  (tx_req),
      .tx_data (tx_data),
      .busy    (busy)
   );

   always #25 clk = ~clk;

   initial forever begin
      @(negedge clk);
      if (rx_valid) begin
         rxq.push_back(rx_data);
         rfq.push_back(rx_first);
      end
      if (tx_req) begin
         txreq_n++;
         tx_data = (txsrc.size() > 0) ? txsrc.pop_front() : 8'hFF;
      end
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got time limit, required finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   task automatic clear_mon();
      wq.delete(); rd_q.delete(); rxq.delete(); rfq.delete(); txsrc.delete();
      nacks = 0; txreq_n = 0; oe_seen = 1'b0; busy_seen = 1'b0; got_ack = 1'b0;
   endtask

   task automatic i2c_start();
      m_low = 1'b0; #Q scl_m = 1'b1; #Q m_low = 1'b1; #Q scl_m = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; #Q scl_m = 1'b1; #Q m_low = 1'b0; #(2*Q);
   endtask

   task automatic wr_bit(input logic b);
      m_low = ~b; #Q scl_m = 1'b1; #(2*Q) scl_m = 1'b0; #Q;
   endtask

   task automatic rd_bit(output logic b);
      m_low = 1'b0; #Q scl_m = 1'b1; #Q b = sda_bus; #Q scl_m = 1'b0; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) wr_bit(b[i]);
      rd_bit(ack);
   endtask

   task automatic rd_byte(output logic [7:0] b);
      for (int i = 7; i >= 0; i--) rd_bit(b[i]);
   endtask

   task automatic xfer(input logic [6:0] a, input logic rw, input int n);
      logic ack;
      logic [7:0] b;
      i2c_start();
      wr_byte({a, rw}, ack);
      got_ack = ~ack;
      if (got_ack) begin
         if (!rw) begin
            foreach (wq[i]) begin
               wr_byte(wq[i], ack);
               if (ack) nacks++;
            end
         end else begin
            for (int i = 0; i < n; i++) begin
               rd_byte(b);
               rd_q.push_back(b);
               wr_bit(i == n - 1);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({sda_oe, rx_valid, rx_first, tx_req, busy} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b required 00000", {sda_oe, rx_valid, rx_first, tx_req, busy});
      end
      total++;
      if (rx_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_rx_data: got %h required 00", rx_data);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_write_single();
      clear_mon();
      wq.push_back(8'h74);
      xfer(7'h2a, 1'b0, 1);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL w1_busy_mid: got %b required 1", busy); end
      i2c_stop();
      total++;
      if (got_ack !== 1'b1 || nacks !== 0) begin
         bad++; $display("FAIL w1_acks: got addr_ack=%b nacks=%0d required 1/0", got_ack, nacks);
      end
      total++;
      if (rxq.size() !== 1) begin
         bad++; $display("FAIL w1_rx_count: got %0d required 1", rxq.size());
      end else begin
         total++;
         if (rxq[0] !== 8'h74 || rfq[0] !== 1'b1) begin
            bad++; $display("FAIL w1_rx_byte: got %h/%b required 74/1", rxq[0], rfq[0]);
         end
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL w1_busy_stop: got %b required 0", busy); end
   endtask

   task automatic test_read_single();
      clear_mon();
      txsrc.push_back(8'hA5);
      xfer(7'h2a, 1'b1, 1);
      repeat (4) @(negedge clk);
      total++;
      if (sda_oe !== 1'b0) begin bad++; $display("FAIL r1_release: got sda_oe=%b required 0", sda_oe); end
      i2c_stop();
      total++;
      if (rd_q.size() !== 1 || got_ack !== 1'b1) begin
         bad++; $display("FAIL r1_count: got %0d bytes ack=%b required 1/1", rd_q.size(), got_ack);
      end else begin
         total++;
         if (rd_q[0] !== 8'hA5) begin bad++; $display("FAIL r1_byte: got %h required a5", rd_q[0]); end
      end
      total++;
      if (txreq_n !== 1) begin bad++; $display("FAIL r1_tx_req: got %0d required 1", txreq_n); end
   endtask

   task automatic test_wrong_addr();
      clear_mon();
      wq.push_back(8'h55);
      xfer(7'h2b, 1'b0, 1);
      i2c_stop();
      total++;
      if (got_ack !== 1'b0) begin bad++; $display("FAIL wa_ack: got %b required 0", got_ack); end
      total++;
      if (oe_seen || busy_seen || rxq.size() != 0) begin
         bad++; $display("FAIL wa_quiet: got oe=%b busy=%b rx=%0d required 0/0/0", oe_seen, busy_seen, rxq.size());
      end
   endtask

   task automatic test_multi_write();
      logic [7:0] exp[3] = '{8'h10, 8'h20, 8'h30};
      clear_mon();
      foreach (exp[i]) wq.push_back(exp[i]);
      xfer(7'h2a, 1'b0, 3);
      i2c_stop();
      total++;
      if (rxq.size() !== 3 || nacks !== 0) begin
         bad++; $display("FAIL mw_count: got %0d nacks=%0d required 3/0", rxq.size(), nacks);
      end else begin
         foreach (exp[i]) begin
            total++;
            if (rxq[i] !== exp[i] || rfq[i] !== (i == 0)) begin
               bad++; $display("FAIL mw_byte%0d: got %h/%b required %h/%b", i, rxq[i], rfq[i], exp[i], i == 0);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      wq.push_back(8'h01);
      xfer(7'h2a, 1'b0, 1);
      txsrc.push_back(8'h5A);
      txsrc.push_back(8'hC3);
      xfer(7'h2a, 1'b1, 2);
      i2c_stop();
      total++;
      if (rxq.size() !== 1) begin
         bad++; $display("FAIL rs_rx_count: got %0d required 1", rxq.size());
      end else begin
         total++;
         if (rxq[0] !== 8'h01 || rfq[0] !== 1'b1) begin
            bad++; $display("FAIL rs_rx_byte: got %h/%b required 01/1", rxq[0], rfq[0]);
         end
      end
      total++;
      if (rd_q.size() !== 2) begin
         bad++; $display("FAIL rs_rd_count: got %0d required 2", rd_q.size());
      end else begin
         total++;
         if (rd_q[0] !== 8'h5A || rd_q[1] !== 8'hC3) begin
            bad++; $display("FAIL rs_rd_bytes: got %h %h required 5a c3", rd_q[0], rd_q[1]);
         end
      end
      total++;
      if (txreq_n !== 2) begin bad++; $display("FAIL rs_tx_req: got %0d required 2", txreq_n); end
   endtask

   task automatic test_reset_mid();
      logic ack;
      clear_mon();
      i2c_start();
      wr_byte({7'h2a, 1'b0}, ack);
      for (int i = 7; i >= 0; i--) wr_bit(i[0]);
      m_low = 1'b0; #Q scl_m = 1'b1; #Q;
      total++;
      if (sda_oe !== 1'b1) begin bad++; $display("FAIL rm_ack_slot: got sda_oe=%b required 1", sda_oe); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (sda_oe !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rm_release: got sda_oe=%b busy=%b required 0/0", sda_oe, busy);
      end
      rst = 1'b0;
      #Q scl_m = 1'b0; #Q;
      i2c_stop();
      test_write_single();
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [6:0] a;
         logic       rw;
         logic       hit;
         int         n;
         logic [7:0] exp[$];
         clear_mon();
         hit = $urandom_range(0, 1);
         a = 7'h2a;
         while (!hit && a == 7'h2a) a = 7'($urandom);
         rw = $urandom_range(0, 1);
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
         if (rw) foreach (exp[i]) txsrc.push_back(exp[i]);
         else    foreach (exp[i]) wq.push_back(exp[i]);
         xfer(a, rw, n);
         i2c_stop();
         total++;
         if (got_ack !== hit || busy_seen !== hit) begin
            bad++; $display("FAIL rnd%0d_ack: got ack=%b busy=%b required %b", it, got_ack, busy_seen, hit);
         end
         total++;
         if (txreq_n !== ((hit && rw) ? n : 0)) begin
            bad++; $display("FAIL rnd%0d_tx_req: got %0d required %0d", it, txreq_n, (hit && rw) ? n : 0);
         end
         if (!rw) begin
            total++;
            if (rxq.size() !== (hit ? n : 0)) begin
               bad++; $display("FAIL rnd%0d_rx_count: got %0d required %0d", it, rxq.size(), hit ? n : 0);
            end else if (hit) begin
               foreach (exp[i]) begin
                  total++;
                  if (rxq[i] !== exp[i] || rfq[i] !== (i == 0)) begin
                     bad++; $display("FAIL rnd%0d_rx%0d: got %h/%b required %h/%b", it, i, rxq[i], rfq[i], exp[i], i == 0);
                  end
               end
            end
         end else if (hit) begin
            total++;
            if (rd_q.size() !== n) begin
               bad++; $display("FAIL rnd%0d_rd_count: got %0d required %0d", it, rd_q.size(), n);
            end else begin
               foreach (exp[i]) begin
                  total++;
                  if (rd_q[i] !== exp[i]) begin
                     bad++; $display("FAIL rnd%0d_rd%0d: got %h required %h", it, i, rd_q[i], exp[i]);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_read_single();
      test_wrong_addr();
      test_multi_write();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
